mskaes_sched: RTL

Two-requester scheduler in front of a single masked AES-128 core (`wrapper_aes128`) and its PRNG. Performs round-robin arbitration between requesters, sequences the core's `valid_in`/`cipher_valid` handshake, and triggers PRNG reseeds at reset and every `RESEED_PERIOD` encryptions. Ciphertext shares are returned to the granted requester with a tag. Shares pass through untouched; the block never recombines data.

---
 rtl/mskaes_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mskaes_sched.sv
// mskaes_sched: round-robin two-requester front end for a masked AES-128 core and its PRNG.
// Optional watchdog abort is compiled in when MSKAES_SCHED_TIMEOUT_EN is defined.
module mskaes_sched #(
    parameter int d             = 2,
    parameter int RESEED_PERIOD = 16,
    parameter int WARMUP        = 30,
    parameter int TIMEOUT       = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*128*d-1:0] req_pt,
    input  logic [2*128*d-1:0] req_key,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [128*d-1:0]   rsp_ct,
    output logic               rsp_err,
    output logic               aes_valid_in,
    input  logic               aes_ready,
    output logic [128*d-1:0]   aes_pt,
    output logic [128*d-1:0]   aes_key,
    input  logic               aes_cipher_valid,
    input  logic [128*d-1:0]   aes_ct,
    output logic               prng_start_reseed,
    input  logic               prng_out_valid
);
    localparam int W      = 128 * d;
    localparam int WARM_W = $clog2(WARMUP + 2);

    typedef enum logic [2:0] {
        S_RESEED, S_WARM, S_IDLE, S_ISSUE, S_BUSY, S_RESP
    } state_t;

    state_t            state;
    logic [WARM_W-1:0] warm_cnt;
    logic [15:0]       enc_cnt;
    logic              prio;
    logic              cur_id;
    logic              reseed_due;
    logic              grant_ok;
    logic              grant_id;
    logic              dispatch;

    assign reseed_due = (enc_cnt == 16'(RESEED_PERIOD));
    assign grant_ok   = (|req_valid) && aes_ready;
    assign grant_id   = (req_valid == 2'b11) ? prio : req_valid[1];
    // A consumed good response arbitrates in the same cycle, so the next grant can follow by one cycle.
    assign dispatch   = (state == S_IDLE) || ((state == S_RESP) && rsp_ready && !rsp_err);

`ifdef MSKAES_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wd_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_RESEED;
            warm_cnt          <= '0;
            enc_cnt           <= '0;
            prio              <= 1'b0;
            cur_id            <= 1'b0;
            req_ready         <= '0;
            rsp_valid         <= 1'b0;
            rsp_id            <= 1'b0;
            rsp_ct            <= '0;
            aes_valid_in      <= 1'b0;
            aes_pt            <= '0;
            aes_key           <= '0;
            prng_start_reseed <= 1'b0;
`ifdef MSKAES_SCHED_TIMEOUT_EN
            rsp_err           <= 1'b0;
            wd_cnt            <= '0;
`endif
        end else begin
            // NOTE: strobes default low here; a later assignment in this block overrides for one cycle.
            req_ready    <= '0;
            aes_valid_in <= 1'b0;

            case (state)
                S_RESEED: begin
                    if (prng_start_reseed) begin
                        prng_start_reseed <= 1'b0;
                        warm_cnt          <= '0;
                        state             <= S_WARM;
                    end else begin
                        prng_start_reseed <= 1'b1;
                    end
                end
                S_WARM: begin
                    if (prng_out_valid || (warm_cnt == WARM_W'(WARMUP)))
                        state <= S_IDLE;
                    else
                        warm_cnt <= warm_cnt + 1'b1;
                end
                S_IDLE: ;
                S_ISSUE: begin
                    aes_valid_in <= 1'b1;
                    enc_cnt      <= enc_cnt + 16'd1;
                    state        <= S_BUSY;
`ifdef MSKAES_SCHED_TIMEOUT_EN
                    wd_cnt       <= '0;
`endif
                end
                S_BUSY: begin
                    if (aes_cipher_valid) begin
                        rsp_ct    <= aes_ct;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        state     <= S_RESP;
                    end
`ifdef MSKAES_SCHED_TIMEOUT_EN
                    else if (wd_cnt == TO_W'(TIMEOUT - 1)) begin
                        rsp_ct    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_id    <= cur_id;
                        enc_cnt   <= '0;
                        state     <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
`ifdef MSKAES_SCHED_TIMEOUT_EN
                        if (rsp_err) begin
                            rsp_err           <= 1'b0;
                            prng_start_reseed <= 1'b1;
                            state             <= S_RESEED;
                        end
`endif
                    end
                end
                default: state <= S_RESEED;
            endcase

            // Reseed wins over pending requests.
            if (dispatch) begin
                if (reseed_due) begin
                    enc_cnt           <= '0;
                    prng_start_reseed <= 1'b1;
                    state             <= S_RESEED;
                end else if (grant_ok) begin
                    req_ready <= grant_id ? 2'b10 : 2'b01;
                    aes_pt    <= grant_id ? req_pt[2*W-1:W]  : req_pt[W-1:0];
                    aes_key   <= grant_id ? req_key[2*W-1:W] : req_key[W-1:0];
                    cur_id    <= grant_id;
                    prio      <= ~grant_id;
                    state     <= S_ISSUE;
                end
            end
        end
    end

endmodule
